fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO. Shares the single write-domain port among NUM_REQ requesters with per-requester valid/ready handshakes. Grants ownership in bursts of up to MAX_BURST beats and throttles on the FIFO full/almost-full flags. Sits in the write clock domain, directly upstream of the write pointer and memory.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_WIDTH, 8, FIFO word width.
- MAX_BURST, 4, maximum beats per grant; must be at least 1.
- clk  in  1  write-domain clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; combinational.
- fifo_full  in  1  FIFO full flag, write domain.
- fifo_afull  in  1  FIFO has exactly one free slot.
- fifo_wr_en  out  1  registered write strobe to the FIFO.
- fifo_wr_data  out  DATA_WIDTH  registered write data.
- grant  out  NUM_REQ  one-hot current owner; all zero in IDLE.
- grant_id  out  clog2(NUM_REQ)  encoded owner; holds the last owner in IDLE.
- busy  out  1  high in OWN.

## Operation
- Two states: IDLE and OWN. Internal registers: owner id g, last_id, beat_cnt (clog2(MAX_BURST+1) bits).
- Reset values:
  - State: IDLE.
  - last_id: NUM_REQ-1, so requester 0 has first priority.
  - beat_cnt: 0.
  - Outputs: grant, grant_id, busy, fifo_wr_en and fifo_wr_data all 0.
- IDLE:
  - req_ready is all 0.
  - If any req_valid is high, pick the first valid requester scanning from (last_id+1) mod NUM_REQ upward with wrap.
  - Set g to that requester, go to OWN, clear beat_cnt.
  - No beat is accepted in the arbitration cycle.
- OWN, ready rule:
  - Only req_ready[g] may be high.
  - req_ready[g] = !fifo_full && !(fifo_wr_en && fifo_afull). The second term covers the write already in flight.
- OWN, transfer and strobe:
  - A transfer occurs when req_valid[g] && req_ready[g].
  - On a transfer: fifo_wr_en <= 1, fifo_wr_data <= req_data[g], beat_cnt increments.
  - Otherwise fifo_wr_en <= 0 and fifo_wr_data holds its value.
- OWN, release conditions:
  - (a) req_valid[g] is low. This releases even if the FIFO is full.
  - (b) A transfer makes beat_cnt reach MAX_BURST.
  - On release: last_id <= g, go to IDLE.
- Full or almost-full stall with req_valid[g] high: ownership and beat_cnt are held, with no timeout.
- Burst cap: a requester released by MAX_BURST that is still valid gets lowest priority at the next arbitration.
- Non-owner request changes have no effect during OWN.
- Data order within a requester is preserved. Beats are never dropped or duplicated.

## Timing
- Arbitration latency: 1 cycle from req_valid rising in IDLE to req_ready.
- Write latency: fifo_wr_en and fifo_wr_data appear 1 cycle after the handshake edge.
- Single continuous requester, no backpressure: MAX_BURST beats per MAX_BURST+1 cycles.
- Asynchronous reset assertion clears all outputs immediately, including mid-burst. Beats handshaken but not yet written are discarded.
- Reset deassertion is used synchronously; the first arbitration occurs in the first cycle after release.

## Test plan
- Reset mid-burst:
  - Stimulus: rst low while owning requester 2 with a write pending.
  - Required: fifo_wr_en, grant and busy go to 0 asynchronously.
  - After release with req_valid = 4'b1001: grant = 4'b0001 first.
- Round robin:
  - Stimulus: all 4 requesters valid continuously, MAX_BURST = 4, flags low.
  - Required: grant order 0,1,2,3,0, each with exactly 4 writes; 16 writes in 20 cycles; one idle cycle between owners.
- Early release:
  - Stimulus: requester 1 valid for exactly 2 beats; requester 3 valid.
  - Required: 2 writes from requester 1, then IDLE, then grant_id = 3.
- Full stall:
  - Stimulus: fifo_full high for 5 cycles mid-burst after beat 2.
  - Required: req_ready = 0, fifo_wr_en = 0, grant held, beat_cnt = 2 throughout.
  - After deassert: beats 3 and 4, then release.
- Almost-full with a write in flight:
  - Stimulus: fifo_afull = 1 while fifo_wr_en = 1.
  - Required: req_ready low that cycle, zero overflow writes.
- Data integrity:
  - Stimulus: random valid and backpressure for 10k cycles, each requester sending an incrementing sequence tagged with its id.
  - Required: each id's sequence is received in order, with no gaps or duplicates.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin write-port arbiter sitting in front of the asynchronous FIFO.
// One requester at a time owns the single write port for a burst of up to
// MAX_BURST beats. An accepted beat reaches the FIFO one cycle later through
// the registered strobe/data pair. The FIFO flags throttle the owner's ready.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   input  logic                          fifo_afull,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   // After reset the scan starts just past the highest id, so requester 0 goes first.
   localparam logic [ID_W-1:0]  LAST_REQ   = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   // Convert an owner id into its one-hot grant vector.
   function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
      logic [NUM_REQ-1:0] oh;
      oh = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         oh[i] = (id == ID_W'(i));
      end
      return oh;
   endfunction

   // State and registered outputs.
   state_t                 state_r, state_s;
   logic [ID_W-1:0]        g_r, g_s;
   logic [ID_W-1:0]        last_id_r, last_id_s;
   logic [CNT_W-1:0]       beat_cnt_r, beat_cnt_s;
   logic                   wr_en_r, wr_en_s;
   logic [DATA_WIDTH-1:0]  wr_data_r, wr_data_s;
   logic [NUM_REQ-1:0]     grant_r, grant_s;
   logic                   busy_r, busy_s;

   // Combinational helpers.
   logic [NUM_REQ-1:0]     above_s;
   logic [ID_W-1:0]        pick_hi_s;
   logic [ID_W-1:0]        pick_lo_s;
   logic [ID_W-1:0]        pick_s;
   logic                   own_valid_s;
   logic [DATA_WIDTH-1:0]  own_data_s;
   logic                   own_ready_s;
   logic                   xfer_s;
   logic [CNT_W-1:0]       beat_next_s;

   // Round-robin pick: lowest valid id above last_id, otherwise wrap to the lowest valid id.
   always_comb begin
      above_s   = {NUM_REQ{1'b0}};
      pick_hi_s = {ID_W{1'b0}};
      pick_lo_s = {ID_W{1'b0}};
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         above_s[i] = req_valid[i] && (ID_W'(i) > last_id_r);
         pick_hi_s  = above_s[i]   ? ID_W'(i) : pick_hi_s;
         pick_lo_s  = req_valid[i] ? ID_W'(i) : pick_lo_s;
      end
      pick_s = (|above_s) ? pick_hi_s : pick_lo_s;
   end

   // Route the current owner's valid and data lanes.
   always_comb begin
      own_valid_s = 1'b0;
      own_data_s  = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         own_valid_s = (g_r == ID_W'(i)) ? req_valid[i] : own_valid_s;
         own_data_s  = (g_r == ID_W'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : own_data_s;
      end
   end

   // Owner may hand over a beat unless the FIFO is full, or the write already
   // in flight would consume the last free slot.
   always_comb begin
      own_ready_s = (state_r == ST_OWN) && !fifo_full && !(wr_en_r && fifo_afull);
      xfer_s      = own_valid_s && own_ready_s;
      beat_next_s = beat_cnt_r + CNT_W'(1'b1);
   end

   assign req_ready = own_ready_s ? id_to_onehot(g_r) : {NUM_REQ{1'b0}};

   // Next-state logic: arbitration in IDLE, beat transfer and release in OWN.
   always_comb begin
      state_s    = state_r;
      g_s        = g_r;
      last_id_s  = last_id_r;
      beat_cnt_s = beat_cnt_r;
      wr_en_s    = 1'b0;
      wr_data_s  = wr_data_r;
      grant_s    = grant_r;
      busy_s     = busy_r;
      case (state_r)
         ST_IDLE: begin
            if (|req_valid) begin
               state_s    = ST_OWN;
               g_s        = pick_s;
               beat_cnt_s = {CNT_W{1'b0}};
               grant_s    = id_to_onehot(pick_s);
               busy_s     = 1'b1;
            end else begin
               grant_s    = {NUM_REQ{1'b0}};
               busy_s     = 1'b0;
            end
         end
         ST_OWN: begin
            if (!own_valid_s) begin
               // Owner went away: release even if the FIFO is stalling us.
               state_s   = ST_IDLE;
               last_id_s = g_r;
               grant_s   = {NUM_REQ{1'b0}};
               busy_s    = 1'b0;
            end else if (xfer_s) begin
               wr_en_s    = 1'b1;
               wr_data_s  = own_data_s;
               beat_cnt_s = beat_next_s;
               if (beat_next_s == BURST_LAST) begin
                  // Burst cap reached: owner drops to lowest priority.
                  state_s   = ST_IDLE;
                  last_id_s = g_r;
                  grant_s   = {NUM_REQ{1'b0}};
                  busy_s    = 1'b0;
               end else begin
                  state_s   = ST_OWN;
               end
            end else begin
               // Flag stall: hold ownership and beat count indefinitely.
               state_s = ST_OWN;
            end
         end
         default: begin
            state_s = ST_IDLE;
            grant_s = {NUM_REQ{1'b0}};
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears everything, dropping any pending write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         g_r        <= {ID_W{1'b0}};
         last_id_r  <= LAST_REQ;
         beat_cnt_r <= {CNT_W{1'b0}};
         wr_en_r    <= 1'b0;
         wr_data_r  <= {DATA_WIDTH{1'b0}};
         grant_r    <= {NUM_REQ{1'b0}};
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         g_r        <= g_s;
         last_id_r  <= last_id_s;
         beat_cnt_r <= beat_cnt_s;
         wr_en_r    <= wr_en_s;
         wr_data_r  <= wr_data_s;
         grant_r    <= grant_s;
         busy_r     <= busy_s;
      end
   end

   assign fifo_wr_en   = wr_en_r;
   assign fifo_wr_data = wr_data_r;
   assign grant        = grant_r;
   assign grant_id     = g_r;
   assign busy         = busy_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Directed and random stimulus for the write-port arbiter. A cycle-level
// behavioural model (owner index, last owner, beat count as plain integers)
// predicts every output; a receiver scoreboard checks per-requester sequence
// order of the words written to the FIFO.
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DW        = 8;
   localparam int MAX_BURST = 4;

   logic                  clk        = 1'b0;
   logic                  rst        = 1'b0;
   logic [NUM_REQ-1:0]    req_valid  = 4'b0000;
   logic [NUM_REQ*DW-1:0] req_data   = 32'h0;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  fifo_full  = 1'b0;
   logic                  fifo_afull = 1'b0;
   logic                  fifo_wr_en;
   logic [DW-1:0]         fifo_wr_data;
   logic [NUM_REQ-1:0]    grant;
   logic [1:0]            grant_id;
   logic                  busy;

   int checks = 0;
   int errors = 0;

   fifo_wr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_WIDTH(DW),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .fifo_full   (fifo_full),
      .fifo_afull  (fifo_afull),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_wr_data(fifo_wr_data),
      .grant       (grant),
      .grant_id    (grant_id),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- source side ----------------
   logic [NUM_REQ-1:0] want = 4'b0000;
   int                 budget [NUM_REQ];   // beats left; negative = unlimited
   logic [5:0]         seq    [NUM_REQ];   // next sequence number per requester
   int                 total_hs = 0;

   task automatic apply();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i]       = want[i] && (budget[i] != 0);
         req_data[i*DW +: DW] = {2'(i), seq[i]};
      end
   endtask

   // One clock: note handshakes at the negedge, advance sources just after posedge.
   task automatic tick();
      logic [NUM_REQ-1:0] hs;
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (hs[i]) begin
            seq[i] = seq[i] + 6'd1;
            total_hs++;
            if (budget[i] > 0) budget[i]--;
         end
      end
      apply();
   endtask

   // ---------------- behavioural model ----------------
   int         m_owner = -1;           // -1: nobody owns the port
   int         m_last  = NUM_REQ - 1;
   int         m_beats = 0;
   int         m_gid   = 0;
   logic       m_wr    = 1'b0;
   logic [7:0] m_data  = 8'h00;
   bit         m_rdy;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_owner = -1;
         m_last  = NUM_REQ - 1;
         m_beats = 0;
         m_gid   = 0;
         m_wr    = 1'b0;
         m_data  = 8'h00;
      end else if (m_owner < 0) begin
         m_wr = 1'b0;
         for (int k = 1; k <= NUM_REQ; k++) begin
            if (m_owner < 0 && req_valid[(m_last + k) % NUM_REQ]) begin
               m_owner = (m_last + k) % NUM_REQ;
               m_gid   = m_owner;
               m_beats = 0;
            end
         end
      end else begin
         m_rdy = !fifo_full && !(m_wr && fifo_afull);
         if (!req_valid[m_owner]) begin
            m_wr    = 1'b0;
            m_last  = m_owner;
            m_owner = -1;
         end else if (m_rdy) begin
            m_wr    = 1'b1;
            m_data  = req_data[m_owner*DW +: DW];
            m_beats = m_beats + 1;
            if (m_beats == MAX_BURST) begin
               m_last  = m_owner;
               m_owner = -1;
            end
         end else begin
            m_wr = 1'b0;
         end
      end
   end

   function automatic logic [3:0] exp_grant();
      return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
   endfunction

   function automatic logic [3:0] exp_ready();
      if (m_owner >= 0 && !fifo_full && !(m_wr && fifo_afull)) return 4'b0001 << m_owner;
      return 4'b0000;
   endfunction

   // ---------------- compare process and receiver ----------------
   bit         chk_en = 1'b0;
   logic [5:0] exp_seq [NUM_REQ];
   int         log_q [$];
   int         nwrites = 0;
   logic [1:0] rx_id;

   always @(negedge clk) begin
      if (chk_en) begin
         check("grant",     32'(grant),      32'(exp_grant()));
         check("grant_id",  32'(grant_id),   32'(m_gid));
         check("busy",      32'(busy),       32'(m_owner >= 0));
         check("fifo_wr_en",32'(fifo_wr_en), 32'(m_wr));
         check("wr_data",   32'(fifo_wr_data), 32'(m_data));
         check("req_ready", 32'(req_ready),  32'(exp_ready()));
      end
      if (rst && fifo_wr_en) begin
         rx_id = fifo_wr_data[7:6];
         check("rx_seq", 32'(fifo_wr_data[5:0]), 32'(exp_seq[rx_id]));
         exp_seq[rx_id] = fifo_wr_data[5:0] + 6'd1;
         log_q.push_back(int'(rx_id));
         nwrites++;
      end
   end

   function automatic int count_id(input int id);
      int n = 0;
      foreach (log_q[j]) if (log_q[j] == id) n++;
      return n;
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      for (int i = 0; i < NUM_REQ; i++) begin
         budget[i]  = -1;
         seq[i]     = 6'd0;
         exp_seq[i] = 6'd0;
      end
      apply();

      // Reset state.
      repeat (2) @(posedge clk);
      chk_en = 1'b1;
      #1;
      check("rst_grant",    32'(grant),      32'h0);
      check("rst_busy",     32'(busy),       32'h0);
      check("rst_wr_en",    32'(fifo_wr_en), 32'h0);
      check("rst_grant_id", 32'(grant_id),   32'h0);
      check("rst_ready",    32'(req_ready),  32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Round robin: all four valid, 16 writes over 20 cycles in order 0,1,2,3.
      want = 4'b1111;
      apply();
      log_q.delete();
      repeat (21) tick();
      check("rr_writes", 32'(log_q.size()), 32'd16);
      for (int j = 0; j < 16 && j < log_q.size(); j++) begin
         check("rr_order", 32'(log_q[j]), 32'(j / 4));
      end
      check("rr_wrap_grant", 32'(grant), 32'h1);
      want = 4'b0000;
      apply();
      repeat (2) tick();

      // Early release: requester 1 sends 2 beats, then requester 3 is granted.
      budget[1] = 2;
      budget[3] = -1;
      want = 4'b1010;
      apply();
      log_q.delete();
      repeat (4) tick();
      check("early_idle", 32'(busy), 32'h0);
      tick();
      check("early_gid",   32'(grant_id), 32'd3);
      check("early_grant", 32'(grant),    32'h8);
      check("early_cnt",   32'(log_q.size()), 32'd2);
      if (log_q.size() == 2) begin
         check("early_id0", 32'(log_q[0]), 32'd1);
         check("early_id1", 32'(log_q[1]), 32'd1);
      end

      // Full stall after beat 2 of requester 3's burst.
      log_q.delete();
      repeat (2) tick();
      fifo_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("stall_wr_en", 32'(fifo_wr_en), 32'h0);
         check("stall_ready", 32'(req_ready),  32'h0);
         check("stall_grant", 32'(grant),      32'h8);
      end
      check("stall_beats", 32'(count_id(3)), 32'd2);
      fifo_full = 1'b0;
      repeat (2) tick();
      check("stall_release", 32'(busy), 32'h0);
      tick();
      check("stall_total", 32'(count_id(3)), 32'd4);

      // Almost-full with a write in flight: ready alternates.
      fifo_afull = 1'b1;
      #1;
      check("afull_ready0", 32'(req_ready), 32'h8);
      tick();
      check("afull_wr1",    32'(fifo_wr_en), 32'h1);
      check("afull_ready1", 32'(req_ready),  32'h0);
      tick();
      check("afull_wr2",    32'(fifo_wr_en), 32'h0);
      check("afull_ready2", 32'(req_ready),  32'h8);
      fifo_afull = 1'b0;
      want = 4'b0000;
      apply();
      repeat (3) tick();

      // Random valid and backpressure.
      for (int n = 0; n < 10000; n++) begin
         want       = 4'($urandom);
         fifo_full  = ($urandom_range(0, 4) == 0);
         fifo_afull = ($urandom_range(0, 3) == 0);
         apply();
         tick();
      end
      want       = 4'b0000;
      fifo_full  = 1'b0;
      fifo_afull = 1'b0;
      apply();
      repeat (4) tick();
      check("rand_conserve", 32'(nwrites), 32'(total_hs));
      for (int i = 0; i < NUM_REQ; i++) begin
         check("rand_final_seq", 32'(exp_seq[i]), 32'(seq[i]));
      end

      // Reset mid-burst while requester 2 owns the port with a write pending.
      want = 4'b0100;
      apply();
      repeat (2) tick();
      check("pre_rst_wr",    32'(fifo_wr_en), 32'h1);
      check("pre_rst_grant", 32'(grant),      32'h4);
      rst = 1'b0;
      #1;
      check("mid_rst_wr",    32'(fifo_wr_en), 32'h0);
      check("mid_rst_grant", 32'(grant),      32'h0);
      check("mid_rst_busy",  32'(busy),       32'h0);
      check("mid_rst_ready", 32'(req_ready),  32'h0);
      for (int i = 0; i < NUM_REQ; i++) exp_seq[i] = seq[i];
      want = 4'b1001;
      apply();
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_grant", 32'(grant),    32'h1);
      check("post_rst_gid",   32'(grant_id), 32'h0);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
